uart_block_rx: RTL and testbench
================================

# uart_block_rx

Serial receive end of the cipher-text RS232 link. Deserialises 8N1 frames from the `RXD` line at a fixed baud divisor and presents each byte with a one-cycle ready strobe. Assembles eight consecutive bytes into a 64-bit block, with byte 0 landing in bits [7:0], matching the transmitter's byte order. Sits on the capture board between the UART pin and the cipher-text checker/logger.

## Interface
- `BAUD_DIV`, default 434: CLK cycles per bit (50 MHz / 115200).
- `GAP_TIMEOUT`, default 8680: idle CLK cycles, while a block is partially assembled, before the partial block is discarded (20 bit times).
- `CLK` in, 1: system clock, rising edge.
- `RST_N` in, 1: reset. Asynchronous, active-low.
- `RXD` in, 1: serial line, idle high, asynchronous to `CLK`.
- `CLR` in, 1: synchronous clear of the block assembler. Does not abort a byte in flight.
- `RX_DATA` out, 8: last received byte. Holds until the next good byte.
- `RX_DATA_READY` out, 1: one-cycle pulse when `RX_DATA` updates.
- `BLOCK` out, 64: last completed block. Holds until the next block.
- `BLOCK_VALID` out, 1: one-cycle pulse when `BLOCK` updates.
- `BYTE_IDX` out, 3: number of bytes currently held toward the next block (0-7).
- `FRAME_ERR` out, 1: one-cycle pulse when the stop bit is sampled low.
- `TIMEOUT_ERR` out, 1: one-cycle pulse when a partial block is discarded on gap timeout.

## Operation
- `RXD` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rxs`.
- Receive FSM, states IDLE, START, DATA, STOP:
  - IDLE: when `rxs` is 0, go to START and load the bit counter with 0.
  - START: at count BAUD_DIV/2−1 (mid start bit), sample `rxs`.
    - 0 → go to DATA, clear the bit index.
    - 1 → glitch. Return to IDLE with no output.
  - DATA: every BAUD_DIV cycles, sample `rxs` into the shift register, LSB first. After 8 samples, go to STOP.
  - STOP: BAUD_DIV cycles later, sample the stop bit, then return to IDLE.
    - Stop bit 1 → good byte: update `RX_DATA` and pulse `RX_DATA_READY`.
    - Stop bit 0 → pulse `FRAME_ERR`. Discard the byte and do not change `BYTE_IDX`.
- Assembler, on each good byte:
  - Write the byte to lane `BYTE_IDX` of the staging register and increment `BYTE_IDX`.
  - On the 8th byte (`BYTE_IDX` wraps 7→0), copy staging plus the new byte to `BLOCK` and pulse `BLOCK_VALID` together with that byte's `RX_DATA_READY`.
- Gap timer:
  - Counts CLK cycles while the FSM is in IDLE and `BYTE_IDX` ≠ 0.
  - Clears whenever the FSM leaves IDLE.
  - On reaching GAP_TIMEOUT, set `BYTE_IDX` to 0 and pulse `TIMEOUT_ERR`. `BLOCK` is unchanged.
- `CLR` sets `BYTE_IDX` and the gap timer to 0.
  - If `CLR` coincides with a good-byte event, the clear wins and the byte is dropped from assembly. `RX_DATA` and `RX_DATA_READY` still fire.
  - A `CLR` coinciding with the 8th byte suppresses `BLOCK_VALID`.
- Counter widths: bit counter is ceil(log2(BAUD_DIV)) bits; gap timer is ceil(log2(GAP_TIMEOUT+1)) bits. Neither counter wraps; both reload on the events above.

## Timing
- Reset values: `RX_DATA` 0, `RX_DATA_READY` 0, `BLOCK` 0, `BLOCK_VALID` 0, `BYTE_IDX` 0, `FRAME_ERR` 0, `TIMEOUT_ERR` 0, FSM IDLE.
- Reset asserted mid-frame aborts immediately with no partial output.
- Latency: a `RXD` edge reaches `rxs` 2 cycles later. `RX_DATA_READY` rises 1 cycle after the stop-bit sample, which falls about 9.5 bit times plus 3 cycles after the start-bit falling edge.
- `BLOCK` and `BYTE_IDX` update on the same edge that `RX_DATA_READY` rises.
- Back-to-back frames are required to work: a start edge seen in the cycle right after the STOP sample is accepted.
- All pulses are exactly one CLK cycle wide. There is no backpressure; the consumer must accept within 1 cycle.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP).
  - `UART_DIV_115200 = 434`.
  - Byte-lane index type.
  - The constant 8 for bytes per block.
- One sub-module, `uart_rx_byte`: synchronizer, FSM and shift register; outputs the byte, a ready pulse and a frame-error pulse.
- The top adds the assembler, gap timer and `CLR` handling.

## Test plan
All scenarios use BAUD_DIV=16 and GAP_TIMEOUT=320.
- Single frame 0xA5 → `RX_DATA`=0xA5, one `RX_DATA_READY` pulse 155±2 cycles after the start edge, `BYTE_IDX`=1.
- Eight back-to-back frames 0x01..0x08 → a single `BLOCK_VALID` with `BLOCK`=0x0807060504030201; `BYTE_IDX` returns to 0.
- Frame 0x3C with the stop bit driven low → `FRAME_ERR` pulse; no `RX_DATA_READY`; `RX_DATA` and `BYTE_IDX` unchanged.
- 8-cycle low glitch on idle `RXD` → no outputs; FSM back in IDLE.
- 3 bytes, then `RXD` idle for 320 cycles → `TIMEOUT_ERR` pulse, `BYTE_IDX`=0. The next 8 bytes 0x11..0x88 → `BLOCK`=0x8877665544332211.
- `RST_N` low at DATA bit 4, then released, then frame 0x5A → all outputs at reset values during reset; afterwards `RX_DATA`=0x5A, `BYTE_IDX`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the cipher-text RS232 receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DIV_115200 = 434;
    localparam int BYTES_PER_BLOCK = 8;

    typedef logic [$clog2(BYTES_PER_BLOCK)-1:0] lane_idx_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, receive FSM and LSB-first shift register.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_DIV_115200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rxd,
    output logic [7:0]  o_data,
    output logic        o_ready,
    output logic        o_frame_err,
    output uart_state_e o_state
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

    logic             r_sync1;
    logic             r_sync2;
    uart_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_ready;
    logic             r_frame_err;

    uart_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_ready_nxt;
    logic             w_frame_err_nxt;
    logic             w_rxs;

    assign w_rxs = r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= i_rxd;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_ready     <= w_ready_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_ready_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            START: begin
                // A start bit that is gone by its midpoint was line noise.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_rxs) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    if (w_rxs) begin
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // The shift register only moves in DATA, so it is stable while o_ready is high.
    assign o_data      = r_shift;
    assign o_ready     = r_ready;
    assign o_frame_err = r_frame_err;
    assign o_state     = r_state;

endmodule

// File: rtl/uart_block_rx.sv
// UART receiver that gathers eight good bytes into a 64-bit block, byte 0 in bits [7:0],
// discarding a partial block after an idle gap or on CLR.
module uart_block_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = UART_DIV_115200,
    parameter int GAP_TIMEOUT = 8680
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RXD,
    input  logic        CLR,
    output logic [7:0]  RX_DATA,
    output logic        RX_DATA_READY,
    output logic [63:0] BLOCK,
    output logic        BLOCK_VALID,
    output logic [2:0]  BYTE_IDX,
    output logic        FRAME_ERR,
    output logic        TIMEOUT_ERR,
    output logic [1:0]  DBG_STATE
);

    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam lane_idx_t LAST_LANE = lane_idx_t'(BYTES_PER_BLOCK - 1);

    logic [7:0]  w_byte;
    logic        w_byte_rdy;
    logic        w_frame_err;
    uart_state_e w_state;
    logic        w_gap_run;
    logic [63:0] w_stage_nxt;

    logic [7:0]       r_rx_data;
    logic             r_rx_ready;
    logic [63:0]      r_stage;
    logic [63:0]      r_block;
    logic             r_block_valid;
    lane_idx_t        r_byte_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_frame_err;
    logic             r_timeout_err;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx_byte (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_rxd       (RXD),
        .o_data      (w_byte),
        .o_ready     (w_byte_rdy),
        .o_frame_err (w_frame_err),
        .o_state     (w_state)
    );

    assign w_gap_run = (w_state == IDLE) && (r_byte_idx != '0);

    always_comb begin
        w_stage_nxt = r_stage;
        w_stage_nxt[{r_byte_idx, 3'b000} +: 8] = w_byte;
    end

    // All outputs are one-cycle strobes with no ready path: a consumer samples
    // RX_DATA/BLOCK in the cycle its strobe is high or the value is superseded later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_data     <= '0;
            r_rx_ready    <= 1'b0;
            r_stage       <= '0;
            r_block       <= '0;
            r_block_valid <= 1'b0;
            r_byte_idx    <= '0;
            r_gap         <= '0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rx_ready    <= 1'b0;
            r_block_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_err   <= w_frame_err;
            if (w_byte_rdy) begin
                r_rx_data  <= w_byte;
                r_rx_ready <= 1'b1;
            end
            // CLR outranks a byte arriving in the same cycle: the byte is still
            // reported on RX_DATA but never joins a block.
            if (CLR) begin
                r_byte_idx <= '0;
                r_gap      <= '0;
            end else if (w_byte_rdy) begin
                r_stage    <= w_stage_nxt;
                r_byte_idx <= r_byte_idx + 1'b1;
                r_gap      <= '0;
                if (r_byte_idx == LAST_LANE) begin
                    r_block       <= w_stage_nxt;
                    r_block_valid <= 1'b1;
                end
            end else if (w_gap_run) begin
                if (r_gap == GAP_LAST) begin
                    r_byte_idx    <= '0;
                    r_gap         <= '0;
                    r_timeout_err <= 1'b1;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end else begin
                r_gap <= '0;
            end
        end
    end

    assign RX_DATA       = r_rx_data;
    assign RX_DATA_READY = r_rx_ready;
    assign BLOCK         = r_block;
    assign BLOCK_VALID   = r_block_valid;
    assign BYTE_IDX      = r_byte_idx;
    assign FRAME_ERR     = r_frame_err;
    assign TIMEOUT_ERR   = r_timeout_err;
    assign DBG_STATE     = w_state;

endmodule

// File: tb/tb_uart_block_rx.sv
// Bench for uart_block_rx: vector table of single frames plus hand-written block,
// glitch, gap-timeout, CLR and mid-frame reset sequences.
module tb_uart_block_rx;

  localparam int BAUD = 16;
  localparam int GAP  = 320;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RXD = 1'b1;
  logic        CLR = 1'b0;
  logic [7:0]  RX_DATA;
  logic        RX_DATA_READY;
  logic [63:0] BLOCK;
  logic        BLOCK_VALID;
  logic [2:0]  BYTE_IDX;
  logic        FRAME_ERR;
  logic        TIMEOUT_ERR;
  logic [1:0]  DBG_STATE;

  uart_block_rx #(
    .BAUD_DIV    (BAUD),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .RXD           (RXD),
    .CLR           (CLR),
    .RX_DATA       (RX_DATA),
    .RX_DATA_READY (RX_DATA_READY),
    .BLOCK         (BLOCK),
    .BLOCK_VALID   (BLOCK_VALID),
    .BYTE_IDX      (BYTE_IDX),
    .FRAME_ERR     (FRAME_ERR),
    .TIMEOUT_ERR   (TIMEOUT_ERR),
    .DBG_STATE     (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- output monitor ----------------
  int n_rdy = 0, n_valid = 0, n_ferr = 0, n_tout = 0, n_wide = 0;
  int rdy_cyc = 0, tout_cyc = 0;
  logic p_rdy = 1'b0, p_valid = 1'b0, p_ferr = 1'b0, p_tout = 1'b0;
  logic [7:0] rx_log[$];

  always @(negedge CLK) begin
    if (RX_DATA_READY) begin
      n_rdy   <= n_rdy + 1;
      rdy_cyc <= cyc;
      rx_log.push_back(RX_DATA);
    end
    if (BLOCK_VALID) n_valid <= n_valid + 1;
    if (FRAME_ERR) n_ferr <= n_ferr + 1;
    if (TIMEOUT_ERR) begin
      n_tout   <= n_tout + 1;
      tout_cyc <= cyc;
    end
    if ((RX_DATA_READY && p_rdy) || (BLOCK_VALID && p_valid) ||
        (FRAME_ERR && p_ferr) || (TIMEOUT_ERR && p_tout))
      n_wide <= n_wide + 1;
    p_rdy   <= RX_DATA_READY;
    p_valid <= BLOCK_VALID;
    p_ferr  <= FRAME_ERR;
    p_tout  <= TIMEOUT_ERR;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int rd_ptr = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_tests++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic drain(input string tag);
    int avail;
    int want;
    avail = rx_log.size() - rd_ptr;
    want  = exp_q.size();
    check({tag, "_sb_count"}, avail, want);
    while (exp_q.size() > 0 && rd_ptr < rx_log.size()) begin
      check($sformatf("%s_sb_byte%0d", tag, rd_ptr), rx_log[rd_ptr], exp_q.pop_front());
      rd_ptr++;
    end
    exp_q.delete();
    rd_ptr = rx_log.size();
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // f[0] is the start bit, f[8:1] data LSB first, f[9] the stop bit.
  task automatic drive_bits(input logic [9:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) start_cyc = cyc;
      RXD = f[i];
      tick(BAUD);
    end
    RXD = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bits({stop, d, 1'b0}, 10);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_rx;
    logic [2:0] exp_idx;
    int         exp_rdy;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s_rdy, s_valid, s_ferr, s_tout, budget, lat;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 3'd1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 3'd1, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 3'd2, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 3'd3, 1, 0};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 3'd4, 1, 0};

    // reset values
    tick(5);
    check("rst_rx_data", RX_DATA, 8'h00);
    check("rst_rdy", RX_DATA_READY, 1'b0);
    check("rst_block", BLOCK, 64'h0);
    check("rst_valid", BLOCK_VALID, 1'b0);
    check("rst_idx", BYTE_IDX, 3'd0);
    check("rst_ferr", FRAME_ERR, 1'b0);
    check("rst_tout", TIMEOUT_ERR, 1'b0);
    check("rst_state", DBG_STATE, 2'd0);
    RST_N = 1'b1;
    tick(5);

    // single-frame vector table
    for (int i = 0; i < 5; i++) begin
      s_rdy  = n_rdy;
      s_ferr = n_ferr;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      tick(20);
      check($sformatf("v%0d_rx_data", i), RX_DATA, vecs[i].exp_rx);
      check($sformatf("v%0d_idx", i), BYTE_IDX, vecs[i].exp_idx);
      check($sformatf("v%0d_rdy_cnt", i), n_rdy - s_rdy, vecs[i].exp_rdy);
      check($sformatf("v%0d_ferr_cnt", i), n_ferr - s_ferr, vecs[i].exp_ferr);
      if (i == 0) begin
        lat = rdy_cyc - start_cyc;
        check_range("v0_latency", lat, 153, 157);
      end
    end
    drain("vec");

    // CLR empties the partial block
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    tick(2);
    check("clr_idx", BYTE_IDX, 3'd0);

    // eight back-to-back frames form one block
    s_rdy   = n_rdy;
    s_valid = n_valid;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1);
    end
    tick(20);
    check("b2b_valid_cnt", n_valid - s_valid, 1);
    check("b2b_rdy_cnt", n_rdy - s_rdy, 8);
    check("b2b_block", BLOCK, 64'h0807060504030201);
    check("b2b_idx", BYTE_IDX, 3'd0);
    drain("b2b");

    // short low glitch on an idle line
    s_rdy   = n_rdy;
    s_ferr  = n_ferr;
    s_valid = n_valid;
    RXD = 1'b0;
    tick(8);
    RXD = 1'b1;
    tick(40);
    check("glitch_rdy_cnt", n_rdy - s_rdy, 0);
    check("glitch_ferr_cnt", n_ferr - s_ferr, 0);
    check("glitch_valid_cnt", n_valid - s_valid, 0);
    check("glitch_state", DBG_STATE, 2'd0);
    check("glitch_idx", BYTE_IDX, 3'd0);

    // partial block discarded after the idle gap
    s_tout  = n_tout;
    s_valid = n_valid;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hBB, 1'b1);
    send_frame(8'hCC, 1'b1);
    tick(2);
    check("gap_idx_before", BYTE_IDX, 3'd3);
    budget = 0;
    while (n_tout == s_tout && budget < 400) begin
      tick(1);
      budget++;
    end
    tick(2);
    check("gap_tout_cnt", n_tout - s_tout, 1);
    check_range("gap_tout_delay", tout_cyc - rdy_cyc, GAP - 2, GAP + 2);
    check("gap_idx_after", BYTE_IDX, 3'd0);
    check("gap_block_kept", BLOCK, 64'h0807060504030201);
    check("gap_valid_cnt", n_valid - s_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(8'(k * 8'h11));
      send_frame(8'(k * 8'h11), 1'b1);
    end
    tick(20);
    check("gap_next_block", BLOCK, 64'h8877665544332211);
    check("gap_next_valid_cnt", n_valid - s_valid, 1);
    drain("gap");

    // CLR held across the eighth byte suppresses the block
    s_rdy   = n_rdy;
    s_valid = n_valid;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(8'hC0 + 8'(k));
      send_frame(8'hC0 + 8'(k), 1'b1);
    end
    tick(2);
    check("clr8_idx_before", BYTE_IDX, 3'd7);
    tick(10);
    exp_q.push_back(8'hC7);
    drive_bits({1'b1, 8'hC7, 1'b0}, 9);
    tick(1);
    CLR = 1'b1;
    tick(20);
    CLR = 1'b0;
    tick(5);
    check("clr8_rdy_cnt", n_rdy - s_rdy, 8);
    check("clr8_valid_cnt", n_valid - s_valid, 0);
    check("clr8_rx_data", RX_DATA, 8'hC7);
    check("clr8_idx", BYTE_IDX, 3'd0);
    check("clr8_block", BLOCK, 64'h8877665544332211);
    drain("clr8");

    // reset in the middle of a frame, then a clean frame
    s_rdy   = n_rdy;
    s_valid = n_valid;
    s_ferr  = n_ferr;
    drive_bits({1'b1, 8'h5A, 1'b0}, 5);
    check("mrst_state_data", DBG_STATE, 2'd2);
    RST_N = 1'b0;
    tick(3);
    check("mrst_rx_data", RX_DATA, 8'h00);
    check("mrst_rdy", RX_DATA_READY, 1'b0);
    check("mrst_block", BLOCK, 64'h0);
    check("mrst_valid", BLOCK_VALID, 1'b0);
    check("mrst_idx", BYTE_IDX, 3'd0);
    check("mrst_ferr", FRAME_ERR, 1'b0);
    check("mrst_tout", TIMEOUT_ERR, 1'b0);
    check("mrst_state", DBG_STATE, 2'd0);
    RST_N = 1'b1;
    tick(10);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(20);
    check("mrst_after_rx_data", RX_DATA, 8'h5A);
    check("mrst_after_idx", BYTE_IDX, 3'd1);
    check("mrst_after_rdy_cnt", n_rdy - s_rdy, 1);
    check("mrst_after_valid_cnt", n_valid - s_valid, 0);
    check("mrst_after_ferr_cnt", n_ferr - s_ferr, 0);
    drain("mrst");

    check("pulse_width", n_wide, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
